// File: rtl/add_mult_arbiter.sv
// Round-robin issue arbiter sharing one pipelined ADD_MULT unit.
// Tags each op with its requester id and routes results back by tag.
module add_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int UTAG_W  = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][63:0]         req_add_left,
  input  logic [N_REQ-1:0][63:0]         req_add_right,
  input  logic [N_REQ-1:0][63:0]         req_mult_right,
  input  logic [N_REQ-1:0][UTAG_W-1:0]   req_utag,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [63:0]                    rsp_result,
  output logic [UTAG_W-1:0]              rsp_utag,
  output logic                           unit_valid,
  output logic [63:0]                    unit_add_left,
  output logic [63:0]                    unit_add_right,
  output logic [63:0]                    unit_mult_right,
  output logic [ID_W+UTAG_W-1:0]         unit_tag,
  input  logic [63:0]                    unit_result,
  input  logic                           unit_done,
  input  logic [ID_W+UTAG_W-1:0]         unit_tag_out,
  input  logic                           unit_stall,
  output logic                           global_stall,
  output logic [ID_W+2:0]                inflight
);

  logic                   unit_valid_q, unit_valid_d;
  logic [63:0]            al_q, al_d, ar_q, ar_d, mr_q, mr_d;
  logic [ID_W+UTAG_W-1:0] tag_q, tag_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0][2:0]  out_cnt_q, out_cnt_d;

  logic             consume, free, hs, gnt_any;
  logic [N_REQ-1:0] elig, grant, hs_vec, ret;
  logic [ID_W-1:0]  gnt_id, rsp_id;

  assign unit_valid      = unit_valid_q;
  assign unit_add_left   = al_q;
  assign unit_add_right  = ar_q;
  assign unit_mult_right = mr_q;
  assign unit_tag        = tag_q;

  // Return path is purely combinational off the unit's held output.
  always_comb begin
    rsp_id     = unit_tag_out[ID_W+UTAG_W-1:UTAG_W];
    rsp_result = unit_result;
    rsp_utag   = unit_tag_out[UTAG_W-1:0];
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = unit_done && (rsp_id == ID_W'(i));
    ret          = rsp_valid & rsp_ready;
    global_stall = unit_done & ~(|ret);
  end

  always_comb begin
    consume = unit_valid_q & ~unit_stall & ~global_stall;
    free    = ~unit_valid_q | consume;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_valid[i] && (out_cnt_q[i] < 3'(MAX_OUT));
  end

  always_comb begin
    int idx;
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_any && elig[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx[ID_W-1:0];
        gnt_any    = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = reset ? (grant & {N_REQ{free}}) : '0;
    hs_vec    = req_valid & req_ready;
    hs        = |hs_vec;
  end

  always_comb begin
    unit_valid_d = unit_valid_q;
    al_d         = al_q;
    ar_d         = ar_q;
    mr_d         = mr_q;
    tag_d        = tag_q;
    rr_ptr_d     = rr_ptr_q;
    if (free)
      unit_valid_d = hs;
    if (hs) begin
      al_d     = req_add_left[gnt_id];
      ar_d     = req_add_right[gnt_id];
      mr_d     = req_mult_right[gnt_id];
      tag_d    = {gnt_id, req_utag[gnt_id]};
      rr_ptr_d = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Issue and return for one requester in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      unique case ({hs_vec[i], ret[i]})
        2'b10: out_cnt_d[i] = out_cnt_q[i] + 3'd1;
        2'b01: if (out_cnt_q[i] != 3'd0)
                 out_cnt_d[i] = out_cnt_q[i] - 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N_REQ; i++)
      inflight = inflight + (ID_W+3)'(out_cnt_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      unit_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      unit_valid_q <= unit_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    al_q  <= al_d;
    ar_q  <= ar_d;
    mr_q  <= mr_d;
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_add_mult_arbiter.sv
// Bench for add_mult_arbiter with a 3-stage ADD_MULT model.
// Scoreboard of expected results in issue order.
module tb_add_mult_arbiter;
  localparam int N = 4, UW = 8, TW = 10, MAXO = 4, DEPTH = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][63:0]    req_al, req_ar, req_mr;
  logic [N-1:0][UW-1:0]  req_utag;
  logic [63:0]           rsp_result;
  logic [UW-1:0]         rsp_utag;
  logic                  unit_valid;
  logic [63:0]           unit_al, unit_ar, unit_mr, unit_result;
  logic [TW-1:0]         unit_tag, unit_tag_out;
  logic                  unit_done, unit_stall, global_stall;
  logic [4:0]            inflight;

  add_mult_arbiter #(.N_REQ(N), .ID_W(2), .UTAG_W(UW), .MAX_OUT(MAXO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_add_left(req_al), .req_add_right(req_ar),
    .req_mult_right(req_mr), .req_utag(req_utag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_utag(rsp_utag),
    .unit_valid(unit_valid), .unit_add_left(unit_al),
    .unit_add_right(unit_ar), .unit_mult_right(unit_mr),
    .unit_tag(unit_tag), .unit_result(unit_result),
    .unit_done(unit_done), .unit_tag_out(unit_tag_out),
    .unit_stall(unit_stall), .global_stall(global_stall),
    .inflight(inflight)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] am(input logic [63:0] a, b, c);
    return $realtobits(($bitstoreal(a) + $bitstoreal(b)) * $bitstoreal(c));
  endfunction

  function automatic logic [63:0] mk();
    return $realtobits($itor($urandom_range(0, 64)) / 8.0);
  endfunction

  // ADD_MULT model: fixed depth, whole pipe freezes on global_stall.
  logic          pv [DEPTH];
  logic [63:0]   pr [DEPTH];
  logic [TW-1:0] pt [DEPTH];
  logic          acc_n = 1'b0;
  logic          gs_n  = 1'b0;
  logic [63:0]   accr_n;
  logic [TW-1:0] acct_n;

  assign unit_done    = pv[DEPTH-1];
  assign unit_result  = pr[DEPTH-1];
  assign unit_tag_out = pt[DEPTH-1];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pv[i] <= 1'b0;
    end else if (!gs_n) begin
      pv[0] <= acc_n;
      pr[0] <= accr_n;
      pt[0] <= acct_n;
      for (int i = 1; i < DEPTH; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
        pt[i] <= pt[i-1];
      end
    end
  end

  typedef struct packed {
    logic [1:0]    id;
    logic [UW-1:0] ut;
    logic [63:0]   res;
  } exp_t;

  exp_t sbq[$];
  int   hs_log[$];
  int   cnt[N];
  int   rsp_n[N];
  int   msum;
  exp_t me;
  logic [1:0] mid;

  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else begin
      msum = 0;
      for (int i = 0; i < N; i++) msum += cnt[i];
      chk("inflight", 64'(inflight), 64'(msum));
      for (int i = 0; i < N; i++)
        if (cnt[i] >= MAXO) chk("full_ready", 64'(req_ready[i]), 0);
      if (unit_done === 1'b1) begin
        mid = unit_tag_out[TW-1:UW];
        if (rsp_ready[mid]) begin
          if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            me = sbq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(4'b1 << me.id));
            chk("rsp_utag", 64'(rsp_utag), 64'(me.ut));
            chk("rsp_result", rsp_result, me.res);
            if (cnt[me.id] == 0) chk("underflow", 1, 0);
            else cnt[me.id]--;
            rsp_n[me.id]++;
          end
        end else begin
          chk("gstall", 64'(global_stall), 1);
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back({2'(i), req_utag[i],
                         am(req_al[i], req_ar[i], req_mr[i])});
          cnt[i]++;
          hs_log.push_back(i);
        end
    end
    acc_n  = reset && unit_valid && !unit_stall && !global_stall;
    accr_n = am(unit_al, unit_ar, unit_mr);
    acct_n = unit_tag;
    gs_n   = global_stall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      req_al[i]   = mk();
      req_ar[i]   = mk();
      req_mr[i]   = mk();
      req_utag[i] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = '1;
    while ((sbq.size() != 0 || unit_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 1);
    @(negedge clk);
    chk("drain_inflight", 64'(inflight), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (unit_done !== 1'b1 && n < 30);
    chk(tag, 64'(unit_done), 1);
  endtask

  logic [UW-1:0] ut1;
  logic [63:0]   al1;

  initial begin
    req_valid  = '0;
    rsp_ready  = '1;
    unit_stall = 1'b0;
    rnd_ops();
    tick();
    tick();
    @(negedge clk);
    chk("rst_uvalid", 64'(unit_valid), 0);
    chk("rst_inflight", 64'(inflight), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_rspv", 64'(rsp_valid), 0);
    chk("rst_gstall", 64'(global_stall), 0);
    tick();
    reset = 1'b1;

    // single op from requester 2
    tick();
    req_al[2]   = 64'h3FF8000000000000;
    req_ar[2]   = 64'h4004000000000000;
    req_mr[2]   = 64'h3FE0000000000000;
    req_utag[2] = 8'h3C;
    req_valid   = 4'b0100;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(unit_valid), 1);
    chk("single_tag", 64'(unit_tag), 10'h23C);
    chk("single_cnt1", 64'(inflight), 1);
    wait_done("single_done");
    chk("single_rspv", 64'(rsp_valid), 4'b0100);
    chk("single_res", rsp_result, 64'h4000000000000000);
    chk("single_utag", 64'(rsp_utag), 8'h3C);
    tick();
    @(negedge clk);
    chk("single_cnt0", 64'(inflight), 0);

    // fairness across all requesters
    do_reset();
    hs_log.delete();
    for (int i = 0; i < N; i++) rsp_n[i] = 0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rnd_ops();
      tick();
    end
    req_valid = '0;
    drain();
    chk("fair_hs", 64'(hs_log.size()), 8);
    for (int k = 0; k < hs_log.size(); k++)
      chk("fair_order", 64'(hs_log[k]), 64'(k % N));
    for (int i = 0; i < N; i++)
      chk("fair_rsp", 64'(rsp_n[i]), 2);

    // outstanding limit with results held back
    do_reset();
    hs_log.delete();
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      rnd_ops();
      @(negedge clk);
      if (unit_done === 1'b1) chk("lim_gstall", 64'(global_stall), 1);
      tick();
    end
    chk("lim_hs", 64'(hs_log.size()), 4);
    @(negedge clk);
    chk("lim_ready", 64'(req_ready[0]), 0);
    chk("lim_gs_hold", 64'(global_stall), 1);
    tick();
    req_valid = '0;
    drain();

    // unit stall with an op held in the issue register
    do_reset();
    hs_log.delete();
    rnd_ops();
    ut1 = req_utag[1];
    al1 = req_al[1];
    req_valid  = 4'b0010;
    unit_stall = 1'b1;
    tick();
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(unit_valid), 1);
      chk("stall_tag", 64'(unit_tag), 64'({2'd1, ut1}));
      chk("stall_al", unit_al, al1);
      chk("stall_ready", 64'(req_ready), 0);
      tick();
    end
    unit_stall = 1'b0;
    @(negedge clk);
    chk("stall_grant", 64'(req_ready), 4'b1000);
    chk("stall_hs", 64'(hs_log.size()), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("stall_next", 64'(unit_tag[TW-1:UW]), 3);
    drain();

    // simultaneous issue and return for requester 1
    do_reset();
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    rnd_ops();
    tick();
    rnd_ops();
    tick();
    req_valid = '0;
    wait_done("sim_done");
    chk("sim_cnt2", 64'(inflight), 2);
    tick();
    rnd_ops();
    rsp_ready = '1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("sim_ready", 64'(req_ready[1]), 1);
    chk("sim_ret", 64'(rsp_valid), 4'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("sim_cnt_after", 64'(inflight), 2);
    drain();

    // reset with ops in flight
    do_reset();
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      rnd_ops();
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("mid_inflight", 64'(inflight), 3);
    tick();
    reset     = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 0);
    tick();
    reset     = 1'b1;
    rsp_ready = '1;
    @(negedge clk);
    chk("mid_uvalid", 64'(unit_valid), 0);
    chk("mid_inflight0", 64'(inflight), 0);
    chk("mid_rspv", 64'(rsp_valid), 0);
    chk("mid_rrptr", 64'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/add_mult_arbiter.md
# add_mult_arbiter

Round-robin scheduler that shares one pipelined ADD_MULT unit (adder feeding multiplier, `result = (add_left + add_right) * mult_right`, IEEE double) among N_REQ requesting Pair-HMM cells. It registers one issued operation toward the unit and stamps it with the requester index. It routes each completed result back to its owner by tag. It enforces a per-requester outstanding-operation limit and applies backpressure into the unit through `global_stall`.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ID_W, 2: requester-index width, $clog2(N_REQ)
- UTAG_W, 8: opaque user tag carried per operation
- MAX_OUT, 4: max in-flight ops per requester (1..7)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; clears all state when 0
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_add_left, req_add_right, req_mult_right  in  N_REQ×64 each  operands
- req_utag  in  N_REQ×UTAG_W  user tag
- rsp_valid  out  N_REQ  one-hot result strobe
- rsp_ready  in  N_REQ  requester can take result
- rsp_result  out  64  result, shared by all requesters
- rsp_utag  out  UTAG_W  returned user tag
- unit_valid, unit_add_left, unit_add_right, unit_mult_right  out  1/64/64/64  to ADD_MULT
- unit_tag  out  ID_W+UTAG_W  {id, utag} to ADD_MULT tag_in
- unit_result, unit_done, unit_tag_out, unit_stall  in  64/1/ID_W+UTAG_W/1  from ADD_MULT
- global_stall  out  1  to ADD_MULT global_stall
- inflight  out  ID_W+3  total ops in flight (status)

## Operation
- Issue register: holds one op (valid bit plus operands plus tag). Drives the `unit_*` outputs directly.
- Consume: the unit takes the op on a cycle with unit_valid=1, unit_stall=0 and global_stall=0.
- Register load: the register may load when `free = !unit_valid || consume`.
- Eligibility: requester i is eligible when req_valid[i]=1 and out_cnt[i] < MAX_OUT.
- Grant: combinational, round-robin. The search starts at rr_ptr and takes the first eligible index upward, mod N_REQ.
- req_ready[i] = grant[i] & free. A handshake (valid & ready) loads the register with {i, req_utag[i]} and the operands.
- rr_ptr update: on a handshake, rr_ptr ← i+1 mod N_REQ. Otherwise rr_ptr is unchanged.
- Return path: id = unit_tag_out[ID_W+UTAG_W-1:UTAG_W].
  - rsp_valid = unit_done ? (1<<id) : 0.
  - rsp_result = unit_result; rsp_utag = unit_tag_out low bits.
- Backpressure: global_stall = unit_done & !rsp_ready[id]. The unit holds the result and the tag until the owner accepts.
- out_cnt[i] (3 bits): +1 on a handshake for i; −1 when unit_done & id==i & rsp_ready[i]. If both happen in the same cycle, the count is unchanged. Never underflows; a bench assertion flags a return to a requester whose out_cnt is 0.
- inflight = sum of out_cnt. This includes the op held in the issue register.

## Timing
- Reset (reset=0 at an edge): unit_valid=0, rr_ptr=0, all out_cnt=0, inflight=0.
  - req_ready=0 while reset=0.
  - rsp_valid and global_stall follow unit_done, which is low after the unit resets.
  - Operands and tags in the register are don't-care.
- Issue latency: handshake at edge k puts unit_valid=1 with that op's operands from cycle k+1. Result latency from consume to unit_done is the ADD_MULT pipeline depth.
- Throughput: one issue per cycle when there is no stall. A new handshake can occur in the same cycle the current op is consumed.
- Stall: if unit_stall or global_stall is high while unit_valid=1, the register holds, req_ready=0 for all, and rr_ptr is frozen.
- Full: a requester with out_cnt=MAX_OUT is skipped and others are served. It becomes eligible the cycle after its count drops.
- Empty: with no eligible requester, unit_valid falls after consume and rr_ptr is held.
- Mid-operation reset: all counts clear and the issue register empties. ADD_MULT shares the same reset, so in-flight results are discarded with no rsp_valid afterwards.

## Test plan
- Single op: requester 2 sends 1.5+2.5, ×0.5, utag 0x3C. Expect req_ready[2] the same cycle, unit_tag={2'd2,8'h3C}, then rsp_valid=4'b0100 with rsp_result=0x4000000000000000 (2.0) and rsp_utag=0x3C. out_cnt[2] goes 0→1→0.
- Fairness: all 4 requesters hold req_valid for 8 cycles with no stalls. Expect grant order 0,1,2,3,0,1,2,3 and exactly 2 results per requester.
- Limit: MAX_OUT=4, requester 0 streams alone while its rsp_ready=0. Expect exactly 4 handshakes, then req_ready[0]=0. global_stall stays high from the first unit_done until rsp_ready[0]=1.
- Unit stall: unit_stall held high 3 cycles with an op in the register. Expect unit_* stable, req_ready=0, rr_ptr unchanged; the op is consumed on the first low cycle.
- Simultaneous: a handshake and a return for requester 1 occur in the same cycle with out_cnt[1]=2. Expect out_cnt[1]=2 afterwards.
- Reset: assert reset=0 with inflight=3. Next cycle expect unit_valid=0, inflight=0, rr_ptr=0, no rsp_valid.
